hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
Central pipeline controller for the 5-stage MIPS core (IF/ID/EX/ME/WB). It sequences the pipeline after reset and detects load-use hazards, inserting bubbles for them. It stretches ME for multi-cycle data-memory loads/stores, flushes wrong-path instructions when a branch resolves taken in ME, and drives the EX-stage forwarding mux selects. It drives the PC write enable, the pipeline-register write enables and the flush/bubble controls.

Parameters:
RESET_HOLD, 2, cycles PC/pipeline held frozen after reset release (0 = none)
MEM_LATENCY, 1, data-memory access cycles; values >1 stall the pipeline while ME holds a load/store
CNT_W, 16, width of performance counters (optional feature)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous active-low reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source (R-type, sw, beq, bne)
ex_rs  in  5  rs of instruction in EX
ex_rt  in  5  rt of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_write_reg  in  5  destination register in EX
me_reg_write  in  1  ME RegWrite
me_write_reg  in  5  ME destination register
me_mem_access  in  1  ME instruction is a lw or sw
wb_reg_write  in  1  WB RegWrite
wb_write_reg  in  5  WB destination register
pc_src_me  in  1  branch taken, resolved in ME
pc_write_en  out  1  PC register load enable
if_id_write_en  out  1  IF/ID load enable
id_ex_write_en  out  1  ID/EX load enable
ex_me_write_en  out  1  EX/ME load enable
if_id_flush  out  1  clear IF/ID on next edge
id_ex_bubble  out  1  load zero controls into ID/EX on next edge
ex_me_flush  out  1  clear EX/ME controls on next edge
me_wb_bubble  out  1  zero RegWrite into ME/WB on next edge
forward_a  out  2  EX source-A select: 00 regfile, 10 ME alu_result, 01 WB write data
forward_b  out  2  EX source-B select, same encoding
stall_count  out  CNT_W  cycles PC was held (optional)
flush_count  out  CNT_W  taken-branch flushes (optional)

Behaviour:
- FSM states: INIT, RUN, LU_STALL, MEM_WAIT. Reset value: INIT, hold counter = RESET_HOLD. Counters reset to 0.
- INIT: all write enables 0, no flush/bubble. Decrements each cycle and enters RUN after RESET_HOLD cycles. With RESET_HOLD=0, leaves INIT on the first edge.
- RUN: all write enables 1, flush/bubble 0, unless a hazard is detected.
- Priority each cycle: pc_src_me > memory wait > load-use.
- Taken branch: pc_src_me=1 in RUN or LU_STALL:
  - Assert if_id_flush, id_ex_bubble, ex_me_flush for that cycle.
  - All write enables 1; PC loads the branch target.
  - Next state RUN, which abandons any load-use stall in progress.
- Memory wait: me_mem_access=1 in RUN and MEM_LATENCY>1:
  - Enter MEM_WAIT with wait counter = MEM_LATENCY-1.
  - pc/if_id/id_ex/ex_me write enables 0; me_wb_bubble 1 each wait cycle.
  - Counter decrements; at 0, releases to RUN with enables 1 and no bubble.
  - pc_src_me is ignored while in MEM_WAIT; the branch flushes on the release cycle. The branch is held in EX/ME, so pc_src_me stays stable.
- Load-use: ex_mem_read=1 and ex_write_reg!=0 and (ex_write_reg==id_rs, or id_uses_rt and ex_write_reg==id_rt):
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1 for exactly one cycle.
  - Goes RUN->LU_STALL->RUN; LU_STALL itself re-evaluates hazards.
- Forwarding (combinational, valid in every state):
  - forward_a=10 if me_reg_write and me_write_reg!=0 and ==ex_rs.
  - Otherwise forward_a=01 if wb_reg_write and wb_write_reg!=0 and ==ex_rs.
  - Otherwise forward_a=00. forward_b is identical using ex_rt.
  - ME wins when ME and WB match the same register.
- Register $0 never causes a stall or a forward.
- Reset asserted mid-stall or mid-wait: immediate return to INIT, all enables 0.
- Outputs are Moore on state plus Mealy on hazard inputs; no output glitches across clock edges are required.

Optional Feature:
HAZARD_PERF_COUNTERS_EN:
- Defined: stall_count increments each cycle pc_write_en=0 outside INIT; flush_count increments each cycle pc_src_me causes a flush. Both saturate at all-ones and clear only on reset.
- Undefined: both outputs are constant 0 and no counter flops are synthesized.

Test Plan:
1. Release reset with RESET_HOLD=2 -> pc_write_en=0 for 2 cycles, then 1; all flushes 0; counters 0.
2. lw $t0 in EX (ex_write_reg=8, ex_mem_read=1), add using $t0 in ID -> one cycle pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, then RUN; stall_count=1.
3. Same as scenario 2 with ex_write_reg=0 -> no stall.
4. pc_src_me=1 in RUN -> if_id_flush=id_ex_bubble=ex_me_flush=1 for one cycle, pc_write_en=1; flush_count=1.
5. Simultaneous load-use and pc_src_me -> flush only, no stall; next cycle RUN.
6. MEM_LATENCY=3, sw reaches ME -> 2 cycles enables 0 with me_wb_bubble=1, then release. me_write_reg=wb_write_reg=ex_rs=5 with both RegWrite=1 -> forward_a=10.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bus: pipeline hazard observations in, pipeline-register controls out.
// master = hazard controller, slave = pipeline datapath.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_write_reg;
    logic             me_reg_write;
    logic [4:0]       me_write_reg;
    logic             me_mem_access;
    logic             wb_reg_write;
    logic [4:0]       wb_write_reg;
    logic             pc_src_me;

    logic             pc_write_en;
    logic             if_id_write_en;
    logic             id_ex_write_en;
    logic             ex_me_write_en;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_me_flush;
    logic             me_wb_bubble;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_write_reg,
               me_reg_write, me_write_reg, me_mem_access, wb_reg_write, wb_write_reg,
               pc_src_me,
        output pc_write_en, if_id_write_en, id_ex_write_en, ex_me_write_en,
               if_id_flush, id_ex_bubble, ex_me_flush, me_wb_bubble,
               forward_a, forward_b, stall_count, flush_count
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_mem_read, ex_write_reg,
               me_reg_write, me_write_reg, me_mem_access, wb_reg_write, wb_write_reg,
               pc_src_me,
        input  pc_write_en, if_id_write_en, id_ex_write_en, ex_me_write_en,
               if_id_flush, id_ex_bubble, ex_me_flush, me_wb_bubble,
               forward_a, forward_b, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline controller for the 5-stage core: reset sequencing, load-use stall, ME wait, branch flush, forwarding.
// Optional stall/flush performance counters enabled by defining HAZARD_PERF_COUNTERS_EN.
//
// state    | meaning
// INIT     | pipeline frozen after reset, hold timer running
// RUN      | normal flow, hazards evaluated each cycle
// LU_STALL | cycle after a load-use bubble, hazards re-evaluated
// MEM_WAIT | ME holds a multi-cycle load/store, front of pipe frozen
module hazard_control_unit #(
    parameter int RESET_HOLD  = 2,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input logic                  clk,
    input logic                  reset,
    hazard_control_unit_if.master bus
);
    localparam int TMR_MAX = (RESET_HOLD > MEM_LATENCY) ? RESET_HOLD : MEM_LATENCY;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {INIT, RUN, LU_STALL, MEM_WAIT} state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic pc_we, if_id_we, id_ex_we, ex_me_we;
    logic if_id_fl, id_ex_bub, ex_me_fl, me_wb_bub;
    logic flush_hit;
    logic load_use, mem_wait_req;

    assign load_use = bus.ex_mem_read && (bus.ex_write_reg != 5'd0) &&
                      ((bus.ex_write_reg == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_write_reg == bus.id_rt)));

    assign mem_wait_req = (MEM_LATENCY > 1) && bus.me_mem_access;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            tmr_q   <= TMR_W'(RESET_HOLD);
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        pc_we     = 1'b0;
        if_id_we  = 1'b0;
        id_ex_we  = 1'b0;
        ex_me_we  = 1'b0;
        if_id_fl  = 1'b0;
        id_ex_bub = 1'b0;
        ex_me_fl  = 1'b0;
        me_wb_bub = 1'b0;
        flush_hit = 1'b0;
        case (state_q)
            INIT: begin
                // one INIT cycle is unavoidable, so hold values 0 and 1 both leave on the first edge
                if (tmr_q <= TMR_W'(1)) begin
                    state_d = RUN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RUN, LU_STALL: begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
                id_ex_we = 1'b1;
                ex_me_we = 1'b1;
                state_d  = RUN;
                if (bus.pc_src_me) begin
                    if_id_fl  = 1'b1;
                    id_ex_bub = 1'b1;
                    ex_me_fl  = 1'b1;
                    flush_hit = 1'b1;
                end else if (mem_wait_req) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_we  = 1'b0;
                    ex_me_we  = 1'b0;
                    me_wb_bub = 1'b1;
                    state_d   = MEM_WAIT;
                    tmr_d     = TMR_W'(MEM_LATENCY - 1);
                end else if (load_use) begin
                    pc_we     = 1'b0;
                    if_id_we  = 1'b0;
                    id_ex_bub = 1'b1;
                    state_d   = LU_STALL;
                end
            end
            MEM_WAIT: begin
                // the access completes in the cycle the decremented count reaches zero
                if (tmr_q <= TMR_W'(1)) begin
                    pc_we    = 1'b1;
                    if_id_we = 1'b1;
                    id_ex_we = 1'b1;
                    ex_me_we = 1'b1;
                    state_d  = RUN;
                    tmr_d    = '0;
                    if (bus.pc_src_me) begin
                        if_id_fl  = 1'b1;
                        id_ex_bub = 1'b1;
                        ex_me_fl  = 1'b1;
                        flush_hit = 1'b1;
                    end
                end else begin
                    me_wb_bub = 1'b1;
                    tmr_d     = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = INIT;
                tmr_d   = TMR_W'(RESET_HOLD);
            end
        endcase
    end

    assign bus.pc_write_en    = pc_we;
    assign bus.if_id_write_en = if_id_we;
    assign bus.id_ex_write_en = id_ex_we;
    assign bus.ex_me_write_en = ex_me_we;
    assign bus.if_id_flush    = if_id_fl;
    assign bus.id_ex_bubble   = id_ex_bub;
    assign bus.ex_me_flush    = ex_me_fl;
    assign bus.me_wb_bubble   = me_wb_bub;

    // ME has the newer value, so it wins over WB on the same register
    assign bus.forward_a = (bus.me_reg_write && bus.me_write_reg != 5'd0 && bus.me_write_reg == bus.ex_rs) ? 2'b10 :
                           (bus.wb_reg_write && bus.wb_write_reg != 5'd0 && bus.wb_write_reg == bus.ex_rs) ? 2'b01 :
                           2'b00;
    assign bus.forward_b = (bus.me_reg_write && bus.me_write_reg != 5'd0 && bus.me_write_reg == bus.ex_rt) ? 2'b10 :
                           (bus.wb_reg_write && bus.wb_write_reg != 5'd0 && bus.wb_write_reg == bus.ex_rt) ? 2'b01 :
                           2'b00;

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q != INIT && !pc_we && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_hit && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif
endmodule
